// File: rtl/secded_pkg.sv
// Shared types and constants for the SECDED memory engine: FSM states, modes,
// decode status codes and Hamming codeword bit positions.
package secded_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_WR_LO,
    ST_WR_HI,
    ST_FIN
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [1:0] STAT_OK   = 2'b00;
  localparam logic [1:0] STAT_CORR = 2'b01;
  localparam logic [1:0] STAT_DBL  = 2'b10;

  localparam int POS_P0 = 0;
  localparam int POS_P1 = 1;
  localparam int POS_P2 = 2;
  localparam int POS_P4 = 4;
  localparam int POS_P8 = 8;

  // Each mask selects the positions whose index has the matching bit set.
  localparam logic [15:0] MASK_P1 = 16'hAAAA;
  localparam logic [15:0] MASK_P2 = 16'hCCCC;
  localparam logic [15:0] MASK_P4 = 16'hF0F0;
  localparam logic [15:0] MASK_P8 = 16'hFF00;

  function automatic logic [15:0] place_data(input logic [10:0] d);
    return {d[10:4], 1'b0, d[3:1], 1'b0, d[0], 3'b000};
  endfunction

  function automatic logic [10:0] extract_data(input logic [15:0] cw);
    return {cw[15:9], cw[7:5], cw[3]};
  endfunction

endpackage

// File: rtl/secded_codec.sv
// Combinational Hamming(16,11) SECDED encoder and decoder/corrector.
module secded_codec
  import secded_pkg::*;
(
  input  logic [10:0] data,
  output logic [15:0] codeword,
  input  logic [15:0] rx,
  output logic [10:0] rx_data,
  output logic [1:0]  status
);

  logic [15:0] base;
  logic [15:0] with_p;
  logic [3:0]  syn;
  logic        q;
  logic [15:0] flip;
  logic [15:0] fixed;

  always_comb begin
    base   = place_data(data);
    with_p = base;
    with_p[POS_P1] = ^(base & MASK_P1);
    with_p[POS_P2] = ^(base & MASK_P2);
    with_p[POS_P4] = ^(base & MASK_P4);
    with_p[POS_P8] = ^(base & MASK_P8);
    codeword = with_p;
    codeword[POS_P0] = ^with_p[15:1];
  end

  always_comb begin
    syn  = {^(rx & MASK_P8), ^(rx & MASK_P4), ^(rx & MASK_P2), ^(rx & MASK_P1)};
    q    = ^rx;
    flip = '0;
    flip[syn] = 1'b1;
    fixed  = rx;
    status = STAT_OK;
    if (syn == 4'd0) begin
      status = q ? STAT_CORR : STAT_OK;
    end else if (q) begin
      // Odd overall parity with a nonzero syndrome: single error at position syn.
      status = STAT_CORR;
      fixed  = rx ^ flip;
    end else begin
      status = STAT_DBL;
    end
    rx_data = extract_data(fixed);
  end

endmodule

// File: rtl/secded_mem_engine.sv
// Memory-to-memory SECDED engine: reads 16-bit messages byte by byte, encodes
// or decodes/corrects them, and writes the results back byte by byte.
module secded_mem_engine
  import secded_pkg::*;
#(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wen,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(NUM_MSG) + 1;

  state_t             state;
  state_t             state_nx;
  logic [IDX_W-1:0]   idx;
  logic [15:0]        work;
  logic               mode_r;
  logic               accept;
  logic               last;
  logic [ADDR_W-1:0]  msg_off;
  logic [15:0]        enc_cw;
  logic [10:0]        dec_data;
  logic [1:0]         dec_status;
  logic [15:0]        result;

  secded_codec u_codec (
    .data     ({work[10:8], work[7:0]}),
    .codeword (enc_cw),
    .rx       (work),
    .rx_data  (dec_data),
    .status   (dec_status)
  );

  assign accept  = start && (state == ST_IDLE || state == ST_FIN);
  assign last    = (idx >= IDX_W'(NUM_MSG - 1));
  assign msg_off = ADDR_W'(idx) << 1;
  assign result  = (mode_r == MODE_ENC) ? enc_cw : {dec_status, 3'b000, dec_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      idx    <= '0;
      work   <= '0;
      mode_r <= MODE_ENC;
    end else begin
      state <= state_nx;
      if (accept) begin
        idx    <= '0;
        mode_r <= mode;
      end
      if (state == ST_RD_LO) work[7:0]  <= mem_rdata;
      if (state == ST_RD_HI) work[15:8] <= mem_rdata;
      if (state == ST_WR_HI && !last) idx <= idx + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_RD_LO;
      ST_RD_LO: state_nx = ST_RD_HI;
      ST_RD_HI: state_nx = ST_WR_LO;
      ST_WR_LO: state_nx = ST_WR_HI;
      ST_WR_HI: state_nx = last ? ST_FIN : ST_RD_LO;
      ST_FIN:   if (start) state_nx = ST_RD_LO;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_RD_LO: begin
        busy     = 1'b1;
        mem_addr = ADDR_W'(SRC_BASE) + msg_off;
      end
      ST_RD_HI: begin
        busy     = 1'b1;
        mem_addr = ADDR_W'(SRC_BASE) + msg_off + ADDR_W'(1);
      end
      ST_WR_LO: begin
        busy      = 1'b1;
        mem_addr  = ADDR_W'(DST_BASE) + msg_off;
        mem_wen   = 1'b1;
        mem_wdata = result[7:0];
      end
      ST_WR_HI: begin
        busy      = 1'b1;
        mem_addr  = ADDR_W'(DST_BASE) + msg_off + ADDR_W'(1);
        mem_wen   = 1'b1;
        mem_wdata = result[15:8];
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/secded_mem_engine.md
SECDED_MEM_ENGINE -- requirements
Module: secded_mem_engine

Interface
REQ-001 SHALL have parameter NUM_MSG, default 15: number of 16-bit messages processed per run (1..64).
REQ-002 SHALL have parameter SRC_BASE, default 0: byte address of the first source message.
REQ-003 SHALL have parameter DST_BASE, default 30: byte address of the first result.
REQ-004 SHALL have parameter ADDR_W, default 8: width of the data-memory address.
REQ-005 SHALL have ports clk (input, 1) and reset (input, 1); one clock; reset is synchronous and active-high.
REQ-006 SHALL have port start (input, 1): single-cycle request to begin a run.
REQ-007 SHALL have port mode (input, 1): 0 = encode, 1 = decode/correct; sampled only on an accepted start.
REQ-008 SHALL have port mem_addr (output, ADDR_W): byte address to the data memory.
REQ-009 SHALL have port mem_rdata (input, 8): combinational read data for mem_addr.
REQ-010 SHALL have ports mem_wen (output, 1) and mem_wdata (output, 8): byte write strobe and write data.
REQ-011 SHALL have port busy (output, 1): run in progress.
REQ-012 SHALL have port done (output, 1): high from run completion until the next accepted start or reset.

Function
REQ-013 Message i SHALL be read from SRC_BASE+2i (low byte) and SRC_BASE+2i+1 (high byte); the result SHALL be written to DST_BASE+2i (low byte) and DST_BASE+2i+1 (high byte).
REQ-014 Codeword bit k (15..0) SHALL hold Hamming position k: {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}.
REQ-015 Encode: source is {5'b0, d11:d9},{d8:d1}; p1/p2/p4/p8 SHALL be even parity over positions with the matching index bit set; p0 SHALL be even parity over bits 15..1.
REQ-016 Decode: syndrome s = XOR of indices of set bits 15..1; overall parity q = XOR of bits 15..0.
REQ-017 Decode status: s=0,q=0 -> 2'b00; s=0,q=1 -> 2'b01 (p0 error); s!=0,q=1 -> 2'b01 with bit s inverted before extraction; s!=0,q=0 -> 2'b10, data extracted uncorrected.
REQ-018 Decode result SHALL be high byte {status, 3'b000, d11:d9}, low byte d8:d1.
REQ-019 FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, FIN; one state per cycle.
REQ-020 Transitions: IDLE -start-> RD_LO; RD_LO -> RD_HI -> WR_LO -> WR_HI; WR_HI -> RD_LO if index < NUM_MSG-1, else FIN; FIN -start-> RD_LO.
REQ-021 RD_LO and RD_HI SHALL latch mem_rdata into the low and high halves of the working register.
REQ-022 mem_wen SHALL be high only in WR_LO and WR_HI.
REQ-023 A run SHALL take exactly 4*NUM_MSG cycles from the cycle after start to the first cycle of FIN; done SHALL be high in FIN; busy SHALL be high in RD_LO..WR_HI.
REQ-024 start while busy SHALL be ignored; start in FIN SHALL clear done and restart with the current mode.
REQ-025 The message index SHALL be a counter of width clog2(NUM_MSG)+1 and SHALL clear on every accepted start.

Reset
REQ-026 reset SHALL force IDLE, index 0, working register 0, busy=0, done=0, mem_wen=0, mem_addr=0, mem_wdata=0.
REQ-027 reset mid-run SHALL abort with no further writes; bytes already written SHALL remain.
REQ-028 reset SHALL take priority over a simultaneous start.

Structure
REQ-029 Package secded_pkg SHALL hold the state enum, the mode constants, the status codes (OK=00, CORR=01, DBL=10) and the codeword bit-position constants.
REQ-030 Sub-module secded_codec (combinational: 11-bit data in -> 16-bit codeword; 16-bit codeword in -> 11-bit data plus 2-bit status) SHALL hold all parity logic.

Verification
REQ-031 Encode, data 11'h7FF and 11'h000 -> writes 16'hFFFF and 16'h0000; done after 4*NUM_MSG cycles.
REQ-032 Decode 16'hFFFF -> high 8'h07, low 8'hFF (status 00); decode 16'hFFDF (bit 5 flipped) -> high 8'h47, low 8'hFF.
REQ-033 Decode 16'hFFFC (bits 1,0 flipped) -> high 8'h87, low 8'hFF; decode 16'hFFFE (p0 only) -> high 8'h47, low 8'hFF.
REQ-034 15 random messages: encode run, then decode run over the results with a random single or double flip -> all statuses and data match the model.
REQ-035 reset asserted on cycle 10 of a run -> IDLE next cycle, no mem_wen afterwards, done=0.
REQ-036 start pulsed while busy -> ignored, cycle count unchanged; start in FIN -> done drops next cycle, second run completes.
